// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: bubble encoding, default
// reset vector and the fetch FSM state encoding.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } if_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, stall hold register,
// and redirect handling that drops the data of an in-flight stale fetch.
module if_stage #(
    parameter logic [31:0] RESET_VECTOR = if_stage_pkg::RESET_VECTOR_DEFAULT,
    parameter logic [31:0] NOP_INSTR    = if_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);
    import if_stage_pkg::*;

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;   // address of the in-flight request being discarded
    logic [31:0] hold_q;
    logic [31:0] pc_inc;
    logic [31:0] redir_pc;

    assign pc_inc   = pc_q + 32'd4;
    assign redir_pc = word_align(redirect_pc_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= word_align(RESET_VECTOR);
            addr_q  <= word_align(RESET_VECTOR);
            hold_q  <= NOP_INSTR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    if (redirect_i) pc_q <= redir_pc;
                end
                FETCH: begin
                    if (redirect_i) begin
                        pc_q <= redir_pc;
                        // the bus still owes us an ack for the old address
                        if (!imem_ack_i) begin
                            state_q <= DISCARD;
                            addr_q  <= pc_q;
                        end
                    end else if (imem_ack_i) begin
                        if (stall_i) begin
                            hold_q  <= imem_rdata_i;
                            state_q <= HOLD;
                        end else begin
                            pc_q <= pc_inc;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc_q    <= redir_pc;
                        state_q <= FETCH;
                    end else if (!stall_i) begin
                        pc_q    <= pc_inc;
                        state_q <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect_i) pc_q <= redir_pc;
                    if (imem_ack_i) state_q <= FETCH;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data is forwarded in its ack cycle, so valid_o depends on imem_ack_i.
    always_comb begin
        imem_req_o    = 1'b0;
        imem_addr_o   = pc_q;
        valid_o       = 1'b0;
        instruction_o = NOP_INSTR;
        pc_o          = pc_q;
        unique case (state_q)
            FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i && !redirect_i) begin
                    valid_o       = 1'b1;
                    instruction_o = imem_rdata_i;
                end
            end
            HOLD: begin
                if (!redirect_i) begin
                    valid_o       = 1'b1;
                    instruction_o = hold_q;
                end
            end
            DISCARD: begin
                imem_req_o  = 1'b1;
                imem_addr_o = addr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage: an imem responder with random latency, and a
// scoreboard holding the expected in-order stream of accepted (pc, instruction).
module tb_if_stage;
    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = if_stage_pkg::NOP_INSTR;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        stall_i = 1'b0, redirect_i = 1'b0, imem_ack_i = 1'b0;
    logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
    logic        imem_req_o, valid_o;
    logic [31:0] imem_addr_o, instruction_o, pc_o;

    if_stage #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .instruction_o(instruction_o),
        .pc_o(pc_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, accepted = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] pend_addr;
    logic [31:0] mon_e;
    int lat_left = -1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // expected accepted stream: consecutive words from the last redirect target
    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] target);
        exp_q.delete();
        model_pc = {target[31:2], 2'b00};
        refill();
    endtask

    // one cycle of stimulus; lat <0 picks a random ack latency for a new request
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input int lat);
        @(posedge clk); #1;
        stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
        if (rd) restart(rpc); else refill();
        if (imem_req_o) begin
            if (lat_left < 0) begin
                lat_left  = (lat >= 0) ? lat : int'($urandom_range(0, 2));
                pend_addr = imem_addr_o;
            end else begin
                chk("addr_stable", imem_addr_o, pend_addr);
            end
            imem_ack_i   = (lat_left == 0);
            imem_rdata_i = imem_ack_i ? mem(imem_addr_o) : 32'hDEAD_BEEF;
            lat_left     = imem_ack_i ? -1 : lat_left - 1;
        end else begin
            imem_ack_i = 1'b0;
            lat_left   = -1;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req_o}, 32'd0);
        chk({tag, "_valid"}, {31'b0, valid_o},    32'd0);
        chk({tag, "_instr"}, instruction_o,       NOP);
        chk({tag, "_pc"},    pc_o,                RV);
    endtask

    // async reset mid-cycle, stale ack while in reset and in IDLE, then release
    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; imem_ack_i = 1'b0;
        lat_left = -1; exp_q.delete();
        #1 chk_reset_outs("rst_async");
        @(posedge clk); #1;
        imem_ack_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
        #1 chk_reset_outs("rst_stale_ack");
        @(posedge clk); #1;
        imem_ack_i = 1'b0; reset_n = 1'b1; restart(RV);
        #1 chk_reset_outs("idle_after_rst");
        imem_ack_i = 1'b1;
        #1 chk("idle_stale_ack_valid", {31'b0, valid_o}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("addr_align", {30'b0, imem_addr_o[1:0]}, 32'd0);
            if (!valid_o) chk("nop_when_invalid", instruction_o, NOP);
            if (redirect_i) chk("valid_on_redirect", {31'b0, valid_o}, 32'd0);
            if (valid_o && !stall_i && !redirect_i) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL scoreboard_empty actual pc=%h required=none", pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_pc", pc_o, mon_e);
                    chk("stream_instr", instruction_o, mem(mon_e));
                end
            end
        end
    end

    initial begin
        do_reset();
        // back-to-back acks: 0,4,8 then ack at 8 under a 3-cycle stall
        step(0, 0, 0, 0); #1 chk("first_addr", imem_addr_o, RV);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0); #1 chk("ack_stall_addr", imem_addr_o, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0); #1;
            chk("hold_req", {31'b0, imem_req_o}, 32'd0);
            chk("hold_instr", instruction_o, mem(32'h8));
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0); #1 chk("after_hold_addr", imem_addr_o, 32'hC);

        // redirect during a slow request at 0x10
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 32'h200, 3); #1 chk("disc_addr0", imem_addr_o, 32'h10);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0); #1;
            chk("disc_addr", imem_addr_o, 32'h10);
            chk("disc_valid", {31'b0, valid_o}, 32'd0);
        end
        step(0, 0, 0, 0); #1 chk("redir_addr", imem_addr_o, 32'h200);

        // redirect to unaligned target with simultaneous stall and ack
        step(1, 1, 32'h103, 0); #1 chk("redir_stall_valid", {31'b0, valid_o}, 32'd0);
        step(0, 0, 0, 0); #1;
        chk("redir_stall_req", {31'b0, imem_req_o}, 32'd1);
        chk("redir_stall_addr", imem_addr_o, 32'h100);

        // pc wrap
        step(0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0); #1 chk("wrap_pre", imem_addr_o, 32'hFFFF_FFFC);
        step(0, 0, 0, 0); #1 chk("wrap_addr", imem_addr_o, 32'h0);

        // reset while a request is pending
        step(0, 0, 0, 3);
        do_reset();
        step(0, 0, 0, 0); #1;
        chk("post_rst_req", {31'b0, imem_req_o}, 32'd1);
        chk("post_rst_addr", imem_addr_o, RV);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic st, rd;
            st = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 6);
            step(st, rd, $urandom(), -1);
        end
        step(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (accepted < 100) begin
            failures++;
            $display("FAIL progress actual=%0d required>=100", accepted);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_VECTOR, 32'h0000_0000, PC loaded at reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
REQ-003 The block SHALL have a single clock and asynchronous, active-low reset: clk, in, 1, rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 stall_i  in  1  downstream IF/ID not accepting; hold current output.
REQ-006 redirect_i  in  1  branch/jump/trap taken; refetch from redirect_pc_i.
REQ-007 redirect_pc_i  in  32  redirect target.
REQ-008 imem_req_o  out  1  fetch request, held until ack.
REQ-009 imem_addr_o  out  32  fetch address, word aligned, stable while imem_req_o high.
REQ-010 imem_ack_i  in  1  read data valid this cycle; only meaningful while imem_req_o high.
REQ-011 imem_rdata_i  in  32  fetched instruction.
REQ-012 instruction_o  out  32  instruction to IF/ID; NOP_INSTR when valid_o low.
REQ-013 pc_o  out  32  address of instruction_o.
REQ-014 valid_o  out  1  instruction_o/pc_o carry a real fetched instruction.

Function
REQ-015 The block SHALL use states IDLE, FETCH, HOLD, DISCARD, with at most one memory request outstanding.
REQ-016 IDLE: imem_req_o=0; SHALL go to FETCH on the next cycle.
REQ-017 FETCH: imem_req_o=1, imem_addr_o=pc; ack with !stall_i -> present rdata combinationally (valid_o=1), pc<=pc+4, stay FETCH; ack with stall_i -> capture rdata into hold register, go HOLD.
REQ-018 HOLD: imem_req_o=0, valid_o=1, present hold register with pc; on !stall_i, pc<=pc+4 and go FETCH.
REQ-019 DISCARD: imem_req_o=1, imem_addr_o unchanged (old pc); on ack, data dropped, valid_o=0, go FETCH.
REQ-020 Redirect SHALL have priority over stall and ack: pc<={redirect_pc_i[31:2],2'b00}, hold register invalidated, valid_o=0 that cycle.
REQ-021 Redirect in FETCH without same-cycle ack -> DISCARD; with same-cycle ack or in HOLD/IDLE -> FETCH.
REQ-022 Redirect in DISCARD SHALL update pc and remain in DISCARD until the pending ack.
REQ-023 Fetch latency: instruction presented in the same cycle as its ack; one-cycle ack gives one instruction per cycle.
REQ-024 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-025 pc_o SHALL equal the address from which instruction_o was fetched; pc_o=pc when valid_o=0.
REQ-026 When valid_o=0, instruction_o SHALL be NOP_INSTR.
REQ-027 imem_addr_o bits[1:0] SHALL always be 0.

Reset
REQ-028 Asserting reset_n low SHALL immediately set: state=IDLE, pc=RESET_VECTOR, hold invalid, imem_req_o=0, valid_o=0, instruction_o=NOP_INSTR, pc_o=RESET_VECTOR.
REQ-029 Reset mid-request SHALL abandon the request; a later stale ack SHALL be ignored while in IDLE.

Structure
REQ-030 NOP_INSTR, RESET_VECTOR default and the state encoding SHALL reside in the shared pipeline package.
REQ-031 The design SHALL be a single module; the pc+4/redirect next-PC mux is kept inline, with no sub-module.

Verification
REQ-032 Reset release, ack every cycle, stall=0 -> addresses 0,4,8,...; pc_o/instruction_o follow rdata with valid_o=1 from the second cycle.
REQ-033 Ack at pc=8 with stall_i=1 for 3 cycles -> HOLD, imem_req_o=0, instruction_o constant; stall drop -> next request addr 12.
REQ-034 Ack delayed 3 cycles at pc=0x10, redirect_i to 0x200 in request cycle 1 -> addr stays 0x10 until ack, data dropped (valid_o=0), next request addr 0x200.
REQ-035 Redirect to 0x103 with stall_i=1 simultaneously -> next request addr 0x100, no stall hold, valid_o=0 that cycle.
REQ-036 pc=32'hFFFF_FFFC, ack, no stall -> next addr 0x0000_0000.
REQ-037 reset_n low while request pending, ack one cycle later -> outputs at reset values, ack ignored, first post-reset addr RESET_VECTOR.
